sar_seq_ctrl: RTL and testbench

//  Parametrised successive-approximation sequencer for the SAR ADC datapath.

---
 rtl/sar_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sar_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sar_seq_ctrl.sv
// sar_seq_ctrl: successive-approximation sequencer for the SAR ADC datapath.
// Holds the track/hold switch for SAMPLE_CYCLES, then runs a binary search
// over WIDTH bits. Each bit's trial code is held for SETTLE_CYCLES, and the
// comparator decision is taken on the last edge of that window.
// Optional build macro: SAR_CONTINUOUS_EN.
//   undefined : single-shot, DONE returns to IDLE and each conversion needs start.
//   defined   : free-running, DONE goes straight back to SAMPLE and busy stays high.
// All outputs come straight from flops.
module sar_seq_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             comp_in,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int MAX_CYC = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int BIT_W   = $clog2(WIDTH) + 1;

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BIT_W-1:0] BIT_ZERO    = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0] BIT_ONE     = {{(BIT_W-1){1'b0}}, 1'b1};
  localparam logic [BIT_W-1:0] MSB_IDX     = BIT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] CODE_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CODE_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [BIT_W-1:0] bit_r, bit_s;
  logic [WIDTH-1:0] code_r, code_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic             sample_r, sample_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] trial_bit_s;
  logic [WIDTH-1:0] decided_s;

  // Next-state and next-output logic; every output is precomputed for the coming cycle.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_s       = bit_r;
    code_s      = code_r;
    result_s    = result_r;
    sample_s    = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    // The bit under trial is the only one the comparator decision can clear.
    trial_bit_s = CODE_ONE << bit_r;
    decided_s   = comp_in ? code_r : (code_r & ~trial_bit_s);

    case (state_r)
      ST_IDLE: begin
        code_s = CODE_ZERO;
        cnt_s  = CNT_ZERO;
        if (start) begin
          state_s  = ST_SAMPLE;
          sample_s = 1'b1;
          busy_s   = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end

      ST_SAMPLE: begin
        busy_s = 1'b1;
        code_s = CODE_ZERO;
        if (cnt_r == SAMPLE_LAST) begin
          // Leave track mode; the first trial is the MSB alone.
          state_s  = ST_CONVERT;
          cnt_s    = CNT_ZERO;
          bit_s    = MSB_IDX;
          code_s   = CODE_ONE << MSB_IDX;
          sample_s = 1'b0;
        end else begin
          cnt_s    = cnt_r + CNT_ONE;
          sample_s = 1'b1;
        end
      end

      ST_CONVERT: begin
        busy_s = 1'b1;
        if (cnt_r == SETTLE_LAST) begin
          cnt_s = CNT_ZERO;
          if (bit_r == BIT_ZERO) begin
            state_s  = ST_DONE;
            done_s   = 1'b1;
            result_s = decided_s;
            code_s   = decided_s;
          end else begin
            // Keep the decided upper bits and set the next lower bit as the trial.
            bit_s  = bit_r - BIT_ONE;
            code_s = decided_s | (CODE_ONE << (bit_r - BIT_ONE));
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_DONE: begin
        cnt_s = CNT_ZERO;
`ifdef SAR_CONTINUOUS_EN
        // Free-running: start the next sample immediately.
        state_s  = ST_SAMPLE;
        sample_s = 1'b1;
        busy_s   = 1'b1;
        code_s   = CODE_ZERO;
`else
        state_s  = ST_IDLE;
        code_s   = CODE_ZERO;
`endif
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        bit_s   = BIT_ZERO;
        code_s  = CODE_ZERO;
      end
    endcase
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      bit_r    <= BIT_ZERO;
      code_r   <= CODE_ZERO;
      result_r <= CODE_ZERO;
      sample_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      bit_r    <= bit_s;
      code_r   <= code_s;
      result_r <= result_s;
      sample_r <= sample_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign sample   = sample_r;
  assign dac_code = code_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Self-checking bench for sar_seq_ctrl.
// Two instances: default parameters (8-bit) and WIDTH=10/SAMPLE=2/SETTLE=3.
// The comparator is modelled as comp_in = (VIN >= dac_code). The expected
// per-cycle behaviour comes from a plain binary-search model plus the
// conversion timeline: sample slots, then trial slots, then done.
// Honours SAR_CONTINUOUS_EN for the free-running variant.
module tb_sar_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start8 = 1'b0;
  logic       start10 = 1'b0;
  logic [7:0] vin8 = 8'h00;
  logic [9:0] vin10 = 10'h000;

  logic       sample8, busy8, done8, comp8;
  logic [7:0] dac8, res8;
  logic       sample10, busy10, done10, comp10;
  logic [9:0] dac10, res10;

  assign comp8  = (vin8 >= dac8);
  assign comp10 = (vin10 >= dac10);

  sar_seq_ctrl u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .comp_in(comp8),
    .sample(sample8), .dac_code(dac8), .busy(busy8), .done(done8), .result(res8)
  );

  sar_seq_ctrl #(.WIDTH(10), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(3)) u_dut10 (
    .clk(clk), .reset(reset), .start(start10), .comp_in(comp10),
    .sample(sample10), .dac_code(dac10), .busy(busy10), .done(done10), .result(res10)
  );

  always #5 clk = ~clk;

`ifdef SAR_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  int          checks = 0;
  int          failures = 0;
  bit          sel = 1'b0;
  logic [15:0] exp_res [2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic s, input logic b, input logic d,
                            input logic [15:0] dac, input logic [15:0] res);
    if (sel) begin
      chk({tag, " w10 sample"}, {15'd0, sample10}, {15'd0, s});
      chk({tag, " w10 busy"}, {15'd0, busy10}, {15'd0, b});
      chk({tag, " w10 done"}, {15'd0, done10}, {15'd0, d});
      chk({tag, " w10 dac_code"}, {6'd0, dac10}, dac);
      chk({tag, " w10 result"}, {6'd0, res10}, res);
    end else begin
      chk({tag, " w8 sample"}, {15'd0, sample8}, {15'd0, s});
      chk({tag, " w8 busy"}, {15'd0, busy8}, {15'd0, b});
      chk({tag, " w8 done"}, {15'd0, done8}, {15'd0, d});
      chk({tag, " w8 dac_code"}, {8'd0, dac8}, dac);
      chk({tag, " w8 result"}, {8'd0, res8}, res);
    end
  endtask

  task automatic set_start(input bit v);
    if (sel) start10 = v;
    else     start8  = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion, checked cycle by cycle from the start edge through DONE.
  // repulse_j: cycle at which start is pulsed again (must be ignored).
  // abort_j:   cycle at which to stop checking and return (for reset tests).
  task automatic conv(input logic [15:0] vin, input bit first, input int repulse_j, input int abort_j);
    int          w, s, t, total, k;
    logic [15:0] v, code, tv, mask;
    logic [15:0] trial [16];
    w    = sel ? 10 : 8;
    s    = sel ? 2 : 1;
    t    = sel ? 3 : 1;
    mask = (16'h0001 << w) - 16'h0001;
    v    = vin & mask;
    // Binary search with an ideal comparator: the trial list and final code.
    code = 16'h0000;
    for (int i = 0; i < w; i++) begin
      tv       = code | (16'h0001 << (w - 1 - i));
      trial[i] = tv;
      if (v >= tv) code = tv;
    end
    if (sel) vin10 = v[9:0];
    else     vin8  = v[7:0];
    if (first || !CONT) set_start(1'b1);
    tick();
    set_start(1'b0);
    total = s + w * t;
    for (int j = 0; j <= total; j++) begin
      if (j == abort_j) return;
      set_start(j == repulse_j);
      if (j < s) begin
        check_outs($sformatf("smp j=%0d", j), 1'b1, 1'b1, 1'b0, 16'h0000, exp_res[sel]);
      end else if (j < total) begin
        k = (j - s) / t;
        check_outs($sformatf("cnv j=%0d", j), 1'b0, 1'b1, 1'b0, trial[k], exp_res[sel]);
      end else begin
        exp_res[sel] = v;
        check_outs($sformatf("done vin=%0h", v), 1'b0, 1'b1, 1'b1, v, v);
        chk("model final code", code, v);
      end
      if (j < total) tick();
    end
    set_start(1'b0);
  endtask

  // Single-shot only: one cycle after DONE the block is back in IDLE.
  task automatic after_done();
`ifndef SAR_CONTINUOUS_EN
    tick();
    check_outs("idle", 1'b0, 1'b0, 1'b0, 16'h0000, exp_res[sel]);
`endif
  endtask

  task automatic check_both_zero(input string tag);
    sel = 1'b0;
    check_outs(tag, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    sel = 1'b1;
    check_outs(tag, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rv;
    exp_res[0] = 16'h0000;
    exp_res[1] = 16'h0000;

    // Reset state.
    repeat (3) tick();
    check_both_zero("reset");
    reset = 1'b1;
    tick();
    tick();
    check_both_zero("post-reset idle");

    // 8-bit directed conversions.
    sel = 1'b0;
    conv(16'h00A5, 1'b1, -1, -1);
    after_done();
    conv(16'h00FF, 1'b0, -1, -1);
    after_done();
    conv(16'h0000, 1'b0, -1, -1);
    after_done();
    conv(16'h003C, 1'b0, 3, -1);
    after_done();
    for (int n = 0; n < 4; n++) begin
      rv = 16'($urandom_range(255, 0));
      conv(rv, 1'b0, -1, -1);
      after_done();
    end

    // Reset held for two cycles in the middle of CONVERT.
    conv(16'h0080, 1'b0, -1, 4);
    reset = 1'b0;
    tick();
    check_both_zero("mid-convert reset c1");
    tick();
    check_both_zero("mid-convert reset c2");
    reset = 1'b1;
    exp_res[0] = 16'h0000;
    exp_res[1] = 16'h0000;
    tick();
    check_both_zero("after mid-convert reset");

    // 10-bit instance with longer sample and settle windows.
    sel = 1'b1;
    conv(16'h02AB, 1'b1, -1, -1);
    after_done();
    conv(16'h03FF, 1'b0, -1, -1);
    after_done();
    for (int n = 0; n < 3; n++) begin
      rv = 16'($urandom_range(1023, 0));
      conv(rv, 1'b0, -1, -1);
      after_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
